// File: rtl/ss_seq_ctrl.sv
// Save-state sequencer: streams mapper regs 0..ADDR_LAST out on save, writes them back on load.
// Save byte every SETTLE+2 cycles at full rate; out_vld holds until out_rdy; in_rdy only while awaiting a load byte.
module ss_seq_ctrl #(
  parameter int ADDR_LAST = 127,
  parameter int RO_ADDR   = 127,
  parameter int SETTLE    = 2,
  parameter int WE_HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] out_dat,
  output logic       out_vld,
  input  logic       out_rdy,
  input  logic [7:0] in_dat,
  input  logic       in_vld,
  output logic       in_rdy
);

  typedef enum logic [2:0] {
    IDLE, S_SET, S_SMP, S_OUT, L_WAIT, L_WR, L_GAP, FIN
  } state_t;

  localparam logic [7:0] LAST_A  = 8'(ADDR_LAST);
  localparam logic [7:0] RO_A    = 8'(RO_ADDR);
  localparam logic [3:0] SET_M1  = 4'(SETTLE - 1);
  localparam logic [3:0] HOLD_M1 = 4'(WE_HOLD - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       abort_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      ss_act     <= 1'b0;
      ss_we      <= 1'b0;
      ss_addr    <= 8'd0;
      ss_wdat    <= 8'd0;
      out_dat    <= 8'd0;
      out_vld    <= 1'b0;
      in_rdy     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_save) begin
            state      <= S_SET;
            ss_addr    <= 8'd0;
            cnt        <= 4'd0;
            busy       <= 1'b1;
            ss_act     <= 1'b1;
            abort_pend <= 1'b0;
          end else if (cmd_load) begin
            state      <= L_WAIT;
            ss_addr    <= 8'd0;
            busy       <= 1'b1;
            ss_act     <= 1'b1;
            in_rdy     <= 1'b1;
            abort_pend <= 1'b0;
          end
        end
        S_SET: begin
          if (abort) begin
            state      <= FIN;
            abort_pend <= 1'b1;
          end else if (cnt == SET_M1) begin
            state <= S_SMP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_SMP: begin
          if (abort) begin
            state      <= FIN;
            abort_pend <= 1'b1;
          end else begin
            out_dat <= ss_rdat;
            out_vld <= 1'b1;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (abort) begin
            out_vld    <= 1'b0;
            state      <= FIN;
            abort_pend <= 1'b1;
          end else if (out_rdy) begin
            out_vld <= 1'b0;
            if (ss_addr == LAST_A) begin
              state <= FIN;
            end else begin
              ss_addr <= ss_addr + 8'd1;
              cnt     <= 4'd0;
              state   <= S_SET;
            end
          end
        end
        L_WAIT: begin
          if (abort) begin
            in_rdy     <= 1'b0;
            state      <= FIN;
            abort_pend <= 1'b1;
          end else if (in_vld && in_rdy) begin
            ss_wdat <= in_dat;
            in_rdy  <= 1'b0;
            // read-only register: byte is swallowed without a strobe
            if (ss_addr == RO_A) begin
              if (ss_addr == LAST_A) begin
                state <= FIN;
              end else begin
                ss_addr <= ss_addr + 8'd1;
                in_rdy  <= 1'b1;
              end
            end else begin
              ss_we <= 1'b1;
              cnt   <= 4'd0;
              state <= L_WR;
            end
          end
        end
        L_WR: begin
          // an abort here waits for the full strobe and hold cycle
          if (abort) abort_pend <= 1'b1;
          if (cnt == HOLD_M1) begin
            ss_we <= 1'b0;
            state <= L_GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        L_GAP: begin
          if (abort || abort_pend) begin
            abort_pend <= 1'b1;
            state      <= FIN;
          end else if (ss_addr == LAST_A) begin
            state <= FIN;
          end else begin
            ss_addr <= ss_addr + 8'd1;
            in_rdy  <= 1'b1;
            state   <= L_WAIT;
          end
        end
        FIN: begin
          ss_act     <= 1'b0;
          busy       <= 1'b0;
          done       <= !abort_pend;
          aborted    <= abort_pend;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_seq_ctrl.sv
// Directed bench for ss_seq_ctrl: save/load streams, command priority, abort and reset.
module tb_ss_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_save = 1'b0;
  logic       cmd_load = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, aborted, ss_act, ss_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, out_dat;
  logic       out_vld;
  logic       out_rdy = 1'b0;
  logic [7:0] in_dat = 8'd0;
  logic       in_vld = 1'b0;
  logic       in_rdy;

  ss_seq_ctrl #(.ADDR_LAST(127), .RO_ADDR(127), .SETTLE(2), .WE_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save), .cmd_load(cmd_load), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat), .out_dat(out_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .in_dat(in_dat), .in_vld(in_vld), .in_rdy(in_rdy)
  );

  // mapper read model
  assign ss_rdat = ss_addr ^ 8'h5A;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // stream and mapper-write monitors
  logic [7:0] rx_q[$];
  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         ww_q[$];
  int done_cnt = 0, abrt_cnt = 0, in_hs = 0, in_rdy_cyc = 0;
  int we_cyc = 0, we_viol = 0, stab_viol = 0, run = 0;
  logic       p_we = 1'b0, p_vld = 1'b0, p_rdy = 1'b0;
  logic [7:0] p_addr = 8'd0, p_wdat = 8'd0, p_dat = 8'd0;

  always @(posedge clk) begin
    if (out_vld && out_rdy) rx_q.push_back(out_dat);
    if (in_vld && in_rdy) in_hs++;
    if (done) done_cnt++;
    if (aborted) abrt_cnt++;
    if (in_rdy) in_rdy_cyc++;
    if (ss_we) begin
      we_cyc++;
      run++;
      if (!ss_act) we_viol++;
      if (p_we && (ss_addr != p_addr || ss_wdat != p_wdat)) we_viol++;
      if (!p_we) begin
        wa_q.push_back(ss_addr);
        wd_q.push_back(ss_wdat);
      end
    end else begin
      if (p_we) begin
        ww_q.push_back(run);
        if (ss_addr != p_addr) we_viol++;
      end
      run = 0;
    end
    if (p_vld && !p_rdy && rst_n && !abort && (!out_vld || out_dat != p_dat)) stab_viol++;
    p_we   = ss_we;
    p_addr = ss_addr;
    p_wdat = ss_wdat;
    p_vld  = out_vld;
    p_rdy  = out_rdy;
    p_dat  = out_dat;
  end

  initial begin
    int cyc, base, err, first_vld, d0, ab0, a0, h0, ww0, w0, r0, s0;

    // reset values
    rst_n = 1'b0;
    tick;
    tick;
    chk("rst_ctl", {busy, done, aborted, ss_act, ss_we, out_vld, in_rdy}, 0);
    chk("rst_addr", ss_addr, 0);
    chk("rst_wdat", ss_wdat, 0);
    chk("rst_odat", out_dat, 0);
    rst_n = 1'b1;
    tick;

    // save at full rate
    out_rdy = 1'b1;
    base = rx_q.size();
    d0 = done_cnt;
    cmd_save = 1'b1;
    tick;
    cmd_save = 1'b0;
    chk("t1_accept", {busy, ss_act}, 2'b11);
    cyc = 0;
    first_vld = 0;
    while (!done && cyc < 2000) begin
      tick;
      cyc++;
      if (out_vld && first_vld == 0) first_vld = cyc;
    end
    chk("t1_first_vld_cyc", first_vld, 3);
    chk("t1_latency", cyc, 513);
    chk("t1_end_state", {busy, ss_act, aborted}, 0);
    tick;
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_nbytes", rx_q.size() - base, 128);
    chk("t1_byte0", rx_q[base], 8'h5A);
    chk("t1_byte127", rx_q[base+127], 8'h25);
    err = 0;
    for (int i = 0; i < 128; i++) if (rx_q[base+i] !== 8'(i ^ 8'h5A)) err++;
    chk("t1_order", err, 0);

    // save+load together, random ready, stray load mid-save
    base = rx_q.size();
    d0 = done_cnt;
    w0 = we_cyc;
    r0 = in_rdy_cyc;
    s0 = stab_viol;
    cmd_save = 1'b1;
    cmd_load = 1'b1;
    tick;
    cmd_save = 1'b0;
    cmd_load = 1'b0;
    chk("t2_save_wins", {busy, ss_act, in_rdy}, 3'b110);
    cyc = 0;
    while (!done && cyc < 5000) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (cyc == 100) cmd_load = 1'b1;
      tick;
      cmd_load = 1'b0;
      cyc++;
    end
    tick;
    out_rdy = 1'b1;
    chk("t2_done_once", done_cnt - d0, 1);
    chk("t2_nbytes", rx_q.size() - base, 128);
    err = 0;
    for (int i = 0; i < 128; i++) if (rx_q[base+i] !== 8'(i ^ 8'h5A)) err++;
    chk("t2_order", err, 0);
    chk("t2_stable", stab_viol - s0, 0);
    chk("t2_no_we", we_cyc - w0, 0);
    chk("t2_no_in_rdy", in_rdy_cyc - r0, 0);

    // full load with input bubbles
    a0 = wa_q.size();
    ww0 = ww_q.size();
    h0 = in_hs;
    d0 = done_cnt;
    cmd_load = 1'b1;
    tick;
    cmd_load = 1'b0;
    chk("t3_accept", {busy, ss_act, in_rdy}, 3'b111);
    cyc = 0;
    while (!done && cyc < 4000) begin
      in_vld = (cyc % 5 != 3);
      in_dat = 8'(in_hs - h0 + 16);
      tick;
      cyc++;
    end
    in_vld = 1'b0;
    tick;
    chk("t3_consumed", in_hs - h0, 128);
    chk("t3_nwrites", wa_q.size() - a0, 127);
    err = 0;
    for (int i = 0; i < 127; i++)
      if (wa_q[a0+i] !== 8'(i) || wd_q[a0+i] !== 8'(i + 16)) err++;
    chk("t3_wr_data", err, 0);
    err = 0;
    for (int i = 0; i < 127; i++) if (ww_q[ww0+i] != 4) err++;
    chk("t3_we_width", err, 0);
    chk("t3_we_stable", we_viol, 0);
    chk("t3_done_once", done_cnt - d0, 1);
    chk("t3_idle", {busy, ss_act, ss_we, in_rdy}, 0);

    // abort on second cycle of the write to addr 3
    a0 = wa_q.size();
    h0 = in_hs;
    d0 = done_cnt;
    ab0 = abrt_cnt;
    in_vld = 1'b1;
    cmd_load = 1'b1;
    tick;
    cmd_load = 1'b0;
    cyc = 0;
    while (!(ss_we && ss_addr == 8'd3) && cyc < 200) begin
      in_dat = 8'(in_hs - h0 + 16);
      tick;
      cyc++;
    end
    chk("t4_reach_addr3", {ss_we, ss_addr}, {1'b1, 8'd3});
    tick;
    abort = 1'b1;
    cyc = 0;
    while (!aborted && cyc < 50) begin
      tick;
      cyc++;
    end
    chk("t4_abort_lat", cyc, 5);
    chk("t4_abort_state", {ss_act, busy, ss_we, in_rdy, done}, 0);
    abort = 1'b0;
    in_vld = 1'b0;
    tick;
    chk("t4_nwrites", wa_q.size() - a0, 4);
    chk("t4_last_width", ww_q[ww_q.size()-1], 4);
    chk("t4_aborted_once", abrt_cnt - ab0, 1);
    chk("t4_no_done", done_cnt - d0, 0);

    // abort while a save byte is stalled
    out_rdy = 1'b0;
    base = rx_q.size();
    cmd_save = 1'b1;
    tick;
    cmd_save = 1'b0;
    cyc = 0;
    while (!out_vld && cyc < 50) begin
      tick;
      cyc++;
    end
    chk("t5_vld", {out_vld, out_dat}, {1'b1, 8'h5A});
    abort = 1'b1;
    tick;
    chk("t5_vld_drop", {out_vld, busy, ss_act}, 3'b011);
    tick;
    chk("t5_aborted", {aborted, ss_act, busy}, 3'b100);
    abort = 1'b0;
    out_rdy = 1'b1;
    tick;
    chk("t5_no_bytes", rx_q.size() - base, 0);

    // reset mid-save, then restart
    d0 = done_cnt;
    ab0 = abrt_cnt;
    cmd_save = 1'b1;
    tick;
    cmd_save = 1'b0;
    cyc = 0;
    while (ss_addr != 8'd50 && cyc < 1000) begin
      tick;
      cyc++;
    end
    chk("t6_reach50", ss_addr, 50);
    rst_n = 1'b0;
    tick;
    chk("t6_rst_ctl", {busy, ss_act, out_vld, ss_we, done, aborted}, 0);
    chk("t6_rst_addr", ss_addr, 0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("t6_no_pulse", (done_cnt - d0) + (abrt_cnt - ab0), 0);
    base = rx_q.size();
    d0 = done_cnt;
    cmd_save = 1'b1;
    tick;
    cmd_save = 1'b0;
    chk("t6_restart", {busy, ss_addr}, {1'b1, 8'd0});
    cyc = 0;
    while (!done && cyc < 2000) begin
      tick;
      cyc++;
    end
    chk("t6_latency", cyc, 513);
    chk("t6_nbytes", rx_q.size() - base, 128);
    chk("t6_byte0", rx_q[base], 8'h5A);
    tick;
    chk("t6_done_once", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/ss_seq_ctrl.md
Name: ss_seq_ctrl

Overview:
Save-state sequencer for the mapper register file exposed through the ss_act/ss_we/ss_addr/ss_rdat interface (e.g. PRG/CHR bank and latch bytes, map_idx at address 127). On a save command it walks ss_addr from 0 to ADDR_LAST and streams each read byte out. On a load command it consumes a byte stream and issues timed ss_we writes. It sits between the mapper and the host-side snapshot buffer and owns ss_act for the duration of a transfer.

Parameters:
ADDR_LAST, 127, last ss_addr visited; transfer length is ADDR_LAST+1 bytes.
RO_ADDR, 127, read-only address: on load its byte is consumed but no ss_we is issued.
SETTLE, 2, clk cycles between an ss_addr change and the ss_rdat sample (1..15).
WE_HOLD, 4, clk cycles ss_we is held per write so it spans at least one mapper m2 edge (1..15).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous reset, active low.
cmd_save  in  1  1-cycle pulse: start a save transfer.
cmd_load  in  1  1-cycle pulse: start a load transfer.
abort  in  1  level: terminate the current transfer.
busy  out  1  high from command accept until return to IDLE.
done  out  1  1-cycle pulse on normal completion.
aborted  out  1  1-cycle pulse on abort completion.
ss_act  out  1  mapper save-state access active.
ss_we  out  1  mapper save-state write strobe.
ss_addr  out  8  mapper save-state register address.
ss_wdat  out  8  write data to mapper (drives cpu_dat path while ss_act).
ss_rdat  in  8  read data from mapper.
out_dat  out  8  save stream data.
out_vld  out  1  save stream valid.
out_rdy  in  1  save stream ready.
in_dat  in  8  load stream data.
in_vld  in  1  load stream valid.
in_rdy  out  1  load stream ready.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. busy, done, aborted, ss_act, ss_we, out_vld, in_rdy = 0. ss_addr, ss_wdat, out_dat = 0. Reset mid-transfer drops everything with no done/aborted pulse.
- States: IDLE, S_SET, S_SMP, S_OUT, L_WAIT, L_WR, L_GAP, FIN.
- IDLE: cmd_save -> S_SET, ss_addr=0, busy=1, ss_act=1. cmd_load -> L_WAIT, ss_addr=0, busy=1, ss_act=1. Both in the same cycle: save wins, load is ignored. Commands are ignored while busy.
- S_SET: settle counter counts SETTLE cycles. Then out_dat<=ss_rdat, out_vld<=1, go to S_OUT.
- S_OUT: out_dat/out_vld held stable until out_rdy. On the handshake cycle (out_vld&out_rdy), out_vld<=0. If ss_addr==ADDR_LAST go to FIN, else ss_addr+1 and go to S_SET. The first byte is therefore valid SETTLE+1 cycles after command accept.
- L_WAIT: in_rdy=1. On in_vld&in_rdy: ss_wdat<=in_dat and in_rdy<=0. If ss_addr==RO_ADDR, skip the write and advance directly as in L_GAP exit. Otherwise ss_we<=1 and go to L_WR.
- L_WR: ss_we held exactly WE_HOLD cycles with ss_addr/ss_wdat stable. Then ss_we<=0 and go to L_GAP.
- L_GAP: one cycle with ss_we=0 and address stable (hold time). If ss_addr==ADDR_LAST go to FIN, else ss_addr+1 and go to L_WAIT.
- FIN: ss_act<=0, done=1 for one cycle, busy<=0, go to IDLE. ss_act deasserts in the same cycle as done.
- abort, sampled every cycle in any non-IDLE state:
  - If in L_WR, finish the current WE_HOLD write plus L_GAP first, so there is never a truncated ss_we.
  - Then go to FIN with aborted=1 instead of done.
  - out_vld and in_rdy drop immediately. No further stream handshakes occur.
- ss_addr never exceeds ADDR_LAST. There is no wrap. 8-bit compare only.
- ss_we is never asserted outside a load, or while ss_act=0.
- Stream rules: out_vld is not deasserted without a handshake, except on abort or reset. in_rdy is high only in L_WAIT.

Test Plan:
- Save, out_rdy=1 constant, mapper model returns ss_rdat={addr^8'h5A}: 128 bytes out in order, byte 0=8'h5A, byte 127=8'h25. done pulses exactly once; total latency 128*(SETTLE+2)+1 cycles.
- Save with out_rdy toggled pseudo-randomly: no byte dropped or duplicated, out_dat stable while out_vld&!out_rdy.
- Load 128 bytes with in_dat=addr+8'h10: mapper model captures addr 0..126 with value addr+16, each ss_we exactly WE_HOLD=4 cycles wide. No ss_we at addr 127; byte still consumed; done after.
- cmd_save and cmd_load in the same cycle: save runs. cmd_load pulsed mid-save is ignored (ss_we never asserts).
- abort asserted on the second cycle of the write to addr 3: that write completes full 4 cycles, then aborted pulses, ss_act=0, addr 4 is never written.
- rst_n=0 mid-save at addr 50: next cycle busy=0, ss_act=0, out_vld=0, ss_addr=0, no done/aborted. A following cmd_save restarts at addr 0.
